// File: rtl/win_scan.sv
// win_scan: sequential N-in-a-row detector for a ROWS x COLS two-player board.
//
// On an accepted start the board is copied into a snapshot. One anchor cell
// is then examined per clock in row-major order. From each anchor four line
// directions are tried in the order H, V, DR, UR. The first matching line ends
// the scan early. If no line matches, the draw flag is evaluated after the
// last anchor.
//
// Parameters:
//   ROWS, COLS  board size. Row 0 is the top row. Both must be >= 2.
//   CONNECT     number of stones in a winning line. Must be >= 2.
//
// Ports:
//   clk         rising-edge clock.
//   rst         synchronous active-high reset. Overrides everything.
//   start       scan request. Accepted only in IDLE.
//   panel_flat  board input. Cell (r,c) is at bits [2*(r*COLS+c) +: 2].
//               Encoding: 00 empty, 01 player A, 10 player B, 11 invalid.
//   busy        high while the FSM is in SCAN.
//   done        one-cycle pulse when the result outputs are valid.
//   win_a       a player A line was found.
//   win_b       a player B line was found.
//   draw        no line was found and the snapshot has no empty cell.
//   invalid     the snapshot contained at least one 11 cell.
//   win_row     anchor row of the reported line.
//   win_col     anchor column of the reported line.
//   win_dir     direction of the reported line:
//               0 = H (r,c+i), 1 = V (r+i,c), 2 = DR (r+i,c+i), 3 = UR (r-i,c+i).
//   win_mask    present only when WIN_SCAN_MASK_EN is defined. It has one bit
//               per cell (index r*COLS+c), set for every cell of the reported
//               line.
//
// Handshake: start is a single-cycle request. It is sampled only while busy is
// low and the FSM is in IDLE. Requests in any other state are dropped, not
// queued. done pulses for one cycle. The result outputs stay stable from the
// done pulse until the next accepted start or rst.
//
// Optional feature macro: WIN_SCAN_MASK_EN.
module win_scan #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int CONNECT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2*ROWS*COLS-1:0]     panel_flat,
  output logic                       busy,
  output logic                       done,
  output logic                       win_a,
  output logic                       win_b,
  output logic                       draw,
  output logic                       invalid,
  output logic [$clog2(ROWS)-1:0]    win_row,
  output logic [$clog2(COLS)-1:0]    win_col,
  output logic [1:0]                 win_dir
`ifdef WIN_SCAN_MASK_EN
  ,
  output logic [ROWS*COLS-1:0]       win_mask
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2*N-1:0] snap_q;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;

  // A cell read that leaves the board returns 00 (empty). An empty cell never
  // matches either player, so lines that run off the edge drop out without a
  // separate bounds check per direction.
  function automatic logic [1:0] cell_at(input logic [2*N-1:0] b,
                                         input int r, input int c);
    logic [1:0] v;
    v = 2'b00;
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
      v = b[2*(r*COLS+c) +: 2];
    return v;
  endfunction

  function automatic int dir_dr(input int d);
    int v;
    case (d)
      0:       v = 0;
      1:       v = 1;
      2:       v = 1;
      default: v = -1;
    endcase
    return v;
  endfunction

  function automatic int dir_dc(input int d);
    int v;
    v = (d == 1) ? 0 : 1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Line evaluation for the current anchor. Only the snapshot is read.
  // ---------------------------------------------------------------------------
  logic       hit;
  logic       hit_b;
  logic [1:0] hit_dir;
  logic       last_anchor;
  logic       has_empty;
  logic       in_invalid;

  always_comb begin
    logic all_a;
    logic all_b;
    logic [1:0] cv;
    hit     = 1'b0;
    hit_b   = 1'b0;
    hit_dir = 2'd0;
    all_a   = 1'b0;
    all_b   = 1'b0;
    cv      = 2'b00;
    // The first direction that matches wins, so the loop order is the priority.
    for (int d = 0; d < 4; d++) begin
      all_a = 1'b1;
      all_b = 1'b1;
      for (int i = 0; i < CONNECT; i++) begin
        cv = cell_at(snap_q, int'(row_q) + dir_dr(d) * i,
                     int'(col_q) + dir_dc(d) * i);
        all_a = all_a & (cv == 2'b01);
        all_b = all_b & (cv == 2'b10);
      end
      if (!hit && (all_a || all_b)) begin
        hit     = 1'b1;
        hit_b   = all_b;
        hit_dir = 2'(d);
      end
    end
  end

  assign last_anchor = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  always_comb begin
    has_empty  = 1'b0;
    in_invalid = 1'b0;
    for (int i = 0; i < N; i++) begin
      has_empty  = has_empty  | (snap_q[2*i +: 2] == 2'b00);
      in_invalid = in_invalid | (panel_flat[2*i +: 2] == 2'b11);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (hit || last_anchor) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SCAN);

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  // done is registered from the DONE state. The pulse therefore appears one
  // cycle after the scan decides, while the FSM has already returned to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done    <= 1'b0;
      win_a   <= 1'b0;
      win_b   <= 1'b0;
      draw    <= 1'b0;
      invalid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      win_dir <= 2'd0;
    end else begin
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= panel_flat;
            row_q   <= '0;
            col_q   <= '0;
            win_a   <= 1'b0;
            win_b   <= 1'b0;
            draw    <= 1'b0;
            invalid <= in_invalid;
            win_row <= '0;
            win_col <= '0;
            win_dir <= 2'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            win_a   <= ~hit_b;
            win_b   <= hit_b;
            win_row <= row_q;
            win_col <= col_q;
            win_dir <= hit_dir;
          end else if (last_anchor) begin
            draw <= ~has_empty;
          end else if (col_q == CW'(COLS - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WIN_SCAN_MASK_EN
  // Cells of the matched line for the current anchor and direction.
  logic [N-1:0] mask_d;

  always_comb begin
    mask_d = '0;
    if (hit) begin
      for (int i = 0; i < CONNECT; i++) begin
        mask_d[(int'(row_q) + dir_dr(int'(hit_dir)) * i) * COLS
               + int'(col_q) + dir_dc(int'(hit_dir)) * i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      win_mask <= '0;
    else if (state_q == IDLE && start)
      win_mask <= '0;
    else if (state_q == SCAN && hit)
      win_mask <= mask_d;
  end
`else
  // Without the mask feature only the anchor and direction describe the line.
`endif

endmodule

// File: tb/tb_win_scan.sv
module tb_win_scan;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int N    = ROWS * COLS;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*N-1:0] panel_flat;
  logic           busy;
  logic           done;
  logic           win_a;
  logic           win_b;
  logic           draw;
  logic           invalid;
  logic [2:0]     win_row;
  logic [2:0]     win_col;
  logic [1:0]     win_dir;
`ifdef WIN_SCAN_MASK_EN
  logic [N-1:0]   win_mask;
`endif

  int checks;
  int failures;

  logic [2*N-1:0] board;

  win_scan #(.ROWS(ROWS), .COLS(COLS), .CONNECT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .panel_flat (panel_flat),
    .busy       (busy),
    .done       (done),
    .win_a      (win_a),
    .win_b      (win_b),
    .draw       (draw),
    .invalid    (invalid),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_dir    (win_dir)
`ifdef WIN_SCAN_MASK_EN
    ,
    .win_mask   (win_mask)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cell(input int r, input int c, input logic [1:0] v);
    board[2*(r*COLS+c) +: 2] = v;
  endtask

  // Drive start with the current board. lat is the index of the edge after
  // which done was seen, counted from the start edge as edge 0, or -1 if done
  // never came. busy_n counts the cycles in which busy was high. If repulse is
  // set, start is raised again during the scan and must be ignored.
  task automatic run_scan(input bit repulse, output int lat, output int busy_n);
    @(negedge clk);
    panel_flat = board;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    panel_flat = ~board;   // the scan must use the snapshot, not this
    lat = -1;
    busy_n = busy ? 1 : 0;
    for (int e = 1; e <= 200; e++) begin
      if (repulse && e == 5) start = 1'b1;
      @(posedge clk);
      #1;
      if (repulse && e == 5) start = 1'b0;
      if (done) begin
        lat = e;
        break;
      end
      if (busy) busy_n++;
    end
    @(posedge clk);
    #1;
    check("done_single_cycle", done, 1'b0);
  endtask

  int lat;
  int busy_n;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    panel_flat = '0;
    board = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {win_a, win_b, draw, invalid}, 4'b0000);
    check("rst_pos", {win_row, win_col, win_dir}, 8'h00);
`ifdef WIN_SCAN_MASK_EN
    check("rst_mask", win_mask, 0);
`endif
    rst = 1'b0;

    // Empty board: full scan, no result flags.
    board = '0;
    run_scan(1'b0, lat, busy_n);
    check("empty_latency", lat, 43);
    check("empty_busy_cycles", busy_n, 42);
    check("empty_flags", {win_a, win_b, draw, invalid}, 4'b0000);

    // A horizontal at (5,2..5) -> anchor 37.
    board = '0;
    for (int i = 2; i <= 5; i++) set_cell(5, i, 2'b01);
    run_scan(1'b0, lat, busy_n);
    check("h_latency", lat, 39);
    check("h_win_ab", {win_a, win_b}, 2'b10);
    check("h_pos", {win_row, win_col, win_dir}, {3'd5, 3'd2, 2'd0});
`ifdef WIN_SCAN_MASK_EN
    check("h_mask", win_mask, 42'hF << 37);
`endif

    // B vertical at (0..3,0) plus A horizontal at (4,0..3) -> B at anchor 0.
    board = '0;
    for (int i = 0; i < 4; i++) set_cell(i, 0, 2'b10);
    for (int i = 0; i < 4; i++) set_cell(4, i, 2'b01);
    run_scan(1'b0, lat, busy_n);
    check("v_latency", lat, 2);
    check("v_win_ab", {win_a, win_b}, 2'b01);
    check("v_pos", {win_row, win_col, win_dir}, {3'd0, 3'd0, 2'd1});
`ifdef WIN_SCAN_MASK_EN
    check("v_mask", win_mask, 42'h1 | (42'h1 << 7) | (42'h1 << 14) | (42'h1 << 21));
`endif

    // B up-right diagonal from (3,0) -> anchor 21.
    board = '0;
    for (int i = 0; i < 4; i++) set_cell(3 - i, i, 2'b10);
    run_scan(1'b0, lat, busy_n);
    check("ur_latency", lat, 23);
    check("ur_win_ab", {win_a, win_b}, 2'b01);
    check("ur_pos", {win_row, win_col, win_dir}, {3'd3, 3'd0, 2'd3});

    // Full board with no line -> draw.
    board = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        set_cell(r, c, (((r + c / 2) % 2) == 0) ? 2'b01 : 2'b10);
    run_scan(1'b0, lat, busy_n);
    check("draw_latency", lat, 43);
    check("draw_flags", {win_a, win_b, draw, invalid}, 4'b0010);
`ifdef WIN_SCAN_MASK_EN
    check("draw_mask", win_mask, 0);
`endif

    // Invalid cell, start pulsed again mid-scan (must be ignored).
    board = '0;
    set_cell(2, 2, 2'b11);
    run_scan(1'b1, lat, busy_n);
    check("inv_latency", lat, 43);
    check("inv_flags", {win_a, win_b, draw, invalid}, 4'b0001);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("inv_no_second_done", {done, busy}, 2'b00);
    end

    // Reset at edge 10 of a scan. invalid was high, so the clear is visible.
    @(negedge clk);
    panel_flat = board;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy_done", {busy, done}, 2'b00);
    check("mid_rst_flags", {win_a, win_b, draw, invalid}, 4'b0000);
    check("mid_rst_pos", {win_row, win_col, win_dir}, 8'h00);
    @(posedge clk);
    #1;
    check("post_rst_idle", {busy, done}, 2'b00);

    // A vertical at (1..4,6) -> anchor 13.
    board = '0;
    for (int i = 1; i <= 4; i++) set_cell(i, 6, 2'b01);
    run_scan(1'b0, lat, busy_n);
    check("v2_latency", lat, 15);
    check("v2_win_ab", {win_a, win_b}, 2'b10);
    check("v2_pos", {win_row, win_col, win_dir}, {3'd1, 3'd6, 2'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
